pipe_rca: RTL and testbench
===========================

Name: pipe_rca

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. Generalises the 8-bit single-cycle adder to WIDTH bits, split into STAGES carry-pipelined segments, with a valid/ready handshake and add/sub mode. It sits between operand registers and the result/display path, so long carry chains no longer limit the clock rate.

Parameters:
WIDTH, 8, operand and sum width in bits; must be divisible by STAGES.
STAGES, 2, pipeline segments; each stage adds WIDTH/STAGES bits (SEG); range 1..WIDTH.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
A  in  WIDTH  first operand
B  in  WIDTH  second operand
Ci  in  1  carry in; ignored when SUB=1
SUB  in  1  0 = A+B+Ci, 1 = A-B (A + ~B + 1)
IN_VALID  in  1  A/B/Ci/SUB valid this cycle
IN_READY  out  1  block accepts the operand this cycle
S  out  WIDTH  sum/difference
Co  out  1  carry out; in SUB mode 1 = no borrow
OVF  out  1  signed two's-complement overflow
OUT_VALID  out  1  S/Co/OVF valid
OUT_READY  in  1  consumer accepts the result this cycle

Behaviour:
- Reset (RST=1 at a CLK edge): all stage valid bits, OUT_VALID, S, Co and OVF clear to 0. The reset takes priority over all inputs. In-flight operations are discarded. IN_READY=1 in the first cycle after reset.
- Stage k (0..STAGES-1) adds operand bits [k*SEG +: SEG] with the carry registered from stage k-1. Stage 0 uses the effective carry-in: Ci when SUB=0, 1 when SUB=1. Effective B = SUB ? ~B : B.
- Operand skew: the upper segments of A/effective B travel delayed in per-stage registers. The lower sum segments travel forward aligned, so all of S leaves together.
- Latency: STAGES cycles from the accept edge to OUT_VALID=1, with no stall. STAGES=1 gives a registered single-cycle adder.
- Advance condition: adv = !OUT_VALID || OUT_READY. IN_READY = adv (combinational).
- Transfer rules: an input is accepted when IN_VALID && IN_READY. An output is consumed when OUT_VALID && OUT_READY.
- When adv=1, every stage shifts forward one step. Bubbles (valid=0) propagate and do not compress.
- When adv=0, all stages hold. S/Co/OVF/OUT_VALID stay stable until consumed.
- Throughput: one op per cycle while OUT_READY=1.
- Simultaneous accept and consume in the same cycle are legal. The pipeline keeps full occupancy.
- Co = carry out of the MSB. OVF = carry into MSB XOR carry out of MSB, computed in the last stage.
- S, Co and OVF are don't-care while OUT_VALID=0, except after reset, when they are 0.
- Ops leave in the order accepted. No reordering, no dropping.

Optional Feature:
Macro PIPE_RCA_SATURATE_EN.
- Defined: when OVF=1, S clamps to the signed limit: 0x7F..F if the true result is positive (A's MSB = 0), 0x80..0 if negative. Co and OVF report as normal.
- Not defined: S wraps modulo 2^WIDTH.
- Latency and handshake are the same in both builds.

Test Plan:
All scenarios use WIDTH=8, STAGES=2 unless stated.
1. Basic add: A=0x3C, B=0x1F, Ci=0, SUB=0 -> S=0x5B, Co=0, OVF=0. OUT_VALID rises exactly 2 cycles after the accept.
2. Carry across segments: A=0xFF, B=0x01, Ci=0 -> S=0x00, Co=1, OVF=0. Separately, A=0x0F, B=0x00, Ci=1 -> S=0x10.
3. Overflow and subtract:
   - A=0x7F, B=0x01 add -> OVF=1, S=0x80 (saturating build: S=0x7F).
   - A=0x05, B=0x07, SUB=1 -> S=0xFE, Co=0, OVF=0.
4. Back-to-back with backpressure: issue 4 ops on consecutive cycles, hold OUT_READY=0 for 3 cycles after the first result, then release.
   - IN_READY=0 for the whole stall.
   - Results appear in order with no loss and no duplication.
   - Then one result per cycle.
5. Reset mid-operation: accept 2 ops, assert RST for 1 cycle before either completes -> OUT_VALID=0, S=0x00, no stale result appears later. A new op accepted after reset completes normally.
6. Parameter sweep: WIDTH=16 with STAGES=1, 4 and 16; randomised A/B/SUB/Ci checked against a golden model -> latency equals STAGES in every case, and every S/Co/OVF value matches.

Source files
------------

// File: rtl/pipe_rca.sv
// pipe_rca: WIDTH-bit ripple-carry adder/subtractor split into STAGES carry-registered segments, valid/ready handshake.
// Build macro PIPE_RCA_SATURATE_EN clamps S to the signed limit on overflow; S wraps when it is undefined.
module pipe_rca #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             OVF,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);
    localparam int SEG = WIDTH / STAGES;

    logic             adv_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] s_r;
    logic             co_r;
    logic             ovf_r;

    // The whole pipe moves as one: any free output slot lets every stage step forward
    assign adv_s     = !out_valid_r || OUT_READY;
    assign IN_READY  = adv_s;
    assign S         = s_r;
    assign Co        = co_r;
    assign OVF       = ovf_r;
    assign OUT_VALID = out_valid_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * SEG;

        logic                 v_in_s;
        logic                 c_in_s;
        logic [IW-1:0]        a_in_s;
        logic [IW-1:0]        b_in_s;
        logic [SEG:0]         seg_sum_s;
        logic [(k+1)*SEG-1:0] lo_next_s;

        assign seg_sum_s = {1'b0, a_in_s[SEG-1:0]} + {1'b0, b_in_s[SEG-1:0]} + {{SEG{1'b0}}, c_in_s};

        if (k == 0) begin : g_src
            assign v_in_s    = IN_VALID;
            assign c_in_s    = SUB ? 1'b1 : Ci;
            assign a_in_s    = A;
            assign b_in_s    = SUB ? ~B : B;
            assign lo_next_s = seg_sum_s[SEG-1:0];
        end else begin : g_src
            // Operands arrive pre-shifted, so this stage always consumes the low SEG bits
            assign v_in_s    = g_stage[k-1].g_mid.v_r;
            assign c_in_s    = g_stage[k-1].g_mid.c_r;
            assign a_in_s    = g_stage[k-1].g_mid.a_r;
            assign b_in_s    = g_stage[k-1].g_mid.b_r;
            assign lo_next_s = {seg_sum_s[SEG-1:0], g_stage[k-1].g_mid.lo_r};
        end

        if (k < STAGES - 1) begin : g_mid
            logic                 v_r;
            logic                 c_r;
            logic [IW-SEG-1:0]    a_r;
            logic [IW-SEG-1:0]    b_r;
            logic [(k+1)*SEG-1:0] lo_r;

            // Segment register: valid, carry, finished low sum bits and the not-yet-added operand bits
            always_ff @(posedge CLK) begin
                if (RST) begin
                    v_r  <= 1'b0;
                    c_r  <= 1'b0;
                    a_r  <= '0;
                    b_r  <= '0;
                    lo_r <= '0;
                end else if (adv_s) begin
                    v_r  <= v_in_s;
                    c_r  <= seg_sum_s[SEG];
                    a_r  <= a_in_s[IW-1:SEG];
                    b_r  <= b_in_s[IW-1:SEG];
                    lo_r <= lo_next_s;
                end
            end
        end else begin : g_last
            logic             c_msb_s;
            logic             ovf_s;
            logic [WIDTH-1:0] s_next_s;

            // Carry into the MSB recovered from the MSB sum bit and its two operand bits
            assign c_msb_s = a_in_s[SEG-1] ^ b_in_s[SEG-1] ^ seg_sum_s[SEG-1];
            assign ovf_s   = c_msb_s ^ seg_sum_s[SEG];

`ifdef PIPE_RCA_SATURATE_EN
            // On overflow the true result has A's sign, so clamp toward that limit
            always_comb begin
                s_next_s = lo_next_s;
                if (ovf_s) begin
                    s_next_s = a_in_s[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    s_next_s = lo_next_s;
                end
            end
`else
            assign s_next_s = lo_next_s;
`endif

            // Output register: results hold while the consumer stalls
            always_ff @(posedge CLK) begin
                if (RST) begin
                    out_valid_r <= 1'b0;
                    s_r         <= '0;
                    co_r        <= 1'b0;
                    ovf_r       <= 1'b0;
                end else if (adv_s) begin
                    out_valid_r <= v_in_s;
                    s_r         <= s_next_s;
                    co_r        <= seg_sum_s[SEG];
                    ovf_r       <= ovf_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_rca.sv
// Self-checking bench for pipe_rca: directed 8-bit vectors, stall and reset sequences, 16-bit sweep over STAGES.
module tb_pipe_rca;
`ifdef PIPE_RCA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int SW_N = 120;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit, two-stage DUT
    logic [7:0] a8, b8, s8;
    logic ci8, sub8, iv8, ir8, co8, ovf8, ov8, or8;

    pipe_rca #(.WIDTH(8), .STAGES(2)) dut (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .Ci(ci8), .SUB(sub8),
        .IN_VALID(iv8), .IN_READY(ir8), .S(s8), .Co(co8), .OVF(ovf8),
        .OUT_VALID(ov8), .OUT_READY(or8)
    );

    // 16-bit sweep DUTs sharing one input stream
    logic [15:0] a16, b16;
    logic ci16, sub16, iv16, or16;
    logic [15:0] s_1, s_4, s_16;
    logic ir_1, co_1, ovf_1, ov_1;
    logic ir_4, co_4, ovf_4, ov_4;
    logic ir_16, co_16, ovf_16, ov_16;

    pipe_rca #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .Ci(ci16), .SUB(sub16),
        .IN_VALID(iv16), .IN_READY(ir_1), .S(s_1), .Co(co_1), .OVF(ovf_1),
        .OUT_VALID(ov_1), .OUT_READY(or16)
    );
    pipe_rca #(.WIDTH(16), .STAGES(4)) dut_s4 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .Ci(ci16), .SUB(sub16),
        .IN_VALID(iv16), .IN_READY(ir_4), .S(s_4), .Co(co_4), .OVF(ovf_4),
        .OUT_VALID(ov_4), .OUT_READY(or16)
    );
    pipe_rca #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .Ci(ci16), .SUB(sub16),
        .IN_VALID(iv16), .IN_READY(ir_16), .S(s_16), .Co(co_16), .OVF(ovf_16),
        .OUT_VALID(ov_16), .OUT_READY(or16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s_wrap;
        logic [7:0] s_sat;
        logic       co;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
        logic       ordy;
        logic       irdy;
        logic       ov;
        logic [7:0] s;
        logic       co;
    } cyc_t;

    vec_t vecs[10];
    cyc_t seq[10];

    logic        hv[SW_N];
    logic [15:0] ha[SW_N];
    logic [15:0] hb[SW_N];
    logic        hci[SW_N];
    logic        hsub[SW_N];
    int          sw_base = 0;
    logic        sw_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] gold16(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic [15:0] s;
        logic        ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : ci)};
        s    = full[15:0];
        ovf  = (a[15] == bb[15]) && (s[15] != a[15]);
        if (SAT && ovf) s = a[15] ? 16'h8000 : 16'h7FFF;
        return {full[16], ovf, s};
    endfunction

    task automatic check_sweep(input string name, input int lat, input logic irdy, input logic ov,
                               input logic [15:0] s, input logic co, input logic ovf);
        int          n;
        logic        ev;
        logic [17:0] g;
        n = cyc - sw_base - lat;
        chk({name, " in_ready"}, irdy, 1);
        if (n >= 0) begin
            ev = (n < SW_N) ? hv[n] : 1'b0;
            chk({name, " out_valid"}, ov, ev);
            if (ev && ov) begin
                g = gold16(ha[n], hb[n], hci[n], hsub[n]);
                chk({name, " S"}, s, g[15:0]);
                chk({name, " Co"}, co, g[17]);
                chk({name, " OVF"}, ovf, g[16]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (sw_chk) begin
            check_sweep("w16s1", 1, ir_1, ov_1, s_1, co_1, ovf_1);
            check_sweep("w16s4", 4, ir_4, ov_4, s_4, co_4, ovf_4);
            check_sweep("w16s16", 16, ir_16, ov_16, s_16, co_16, ovf_16);
        end
    end

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(posedge clk); #1;
        a8 = v.a; b8 = v.b; ci8 = v.ci; sub8 = v.sub; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        chk({name, " in_ready"}, ir8, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, 2);
        chk({name, " S"}, s8, SAT ? v.s_sat : v.s_wrap);
        chk({name, " Co"}, co8, v.co);
        chk({name, " OVF"}, ovf8, v.ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h3C, 8'h1F, 1'b0, 1'b0, 8'h5B, 8'h5B, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h50, 8'hB0, 1'b0, 1'b1, 8'hA0, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h20, 8'h01, 1'b1, 1'b1, 8'h1F, 8'h1F, 1'b1, 1'b0};
        vecs[9] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        //           iv    a      b      ordy  irdy  ov    s      co
        seq[0] = '{1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        seq[1] = '{1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        seq[2] = '{1'b1, 8'h40, 8'h01, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0};
        seq[3] = '{1'b1, 8'h40, 8'h01, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0};
        seq[4] = '{1'b1, 8'h40, 8'h01, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0};
        seq[5] = '{1'b1, 8'h40, 8'h01, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
        seq[6] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0};
        seq[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0};
        seq[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b1};
        seq[9] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

        rst = 1'b1;
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0; sub8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
        a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", ov8, 0);
        chk("reset S", s8, 0);
        chk("reset Co", co8, 0);
        chk("reset OVF", ovf8, 0);
        chk("reset in_ready", ir8, 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back issue with a three-cycle consumer stall
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1; sub8 = 1'b0; ci8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int t = 0; t < 10; t++) begin
            iv8 = seq[t].iv; a8 = seq[t].a; b8 = seq[t].b; or8 = seq[t].ordy;
            @(negedge clk);
            chk($sformatf("stall t%0d in_ready", t), ir8, seq[t].irdy);
            chk($sformatf("stall t%0d out_valid", t), ov8, seq[t].ov);
            if (seq[t].ov) begin
                chk($sformatf("stall t%0d S", t), s8, seq[t].s);
                chk($sformatf("stall t%0d Co", t), co8, seq[t].co);
            end
            @(posedge clk); #1;
        end

        // Reset while two operations are in flight
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; or8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h02; b8 = 8'h02; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv8 = 1'b0;
        @(negedge clk);
        chk("midrst out_valid", ov8, 0);
        chk("midrst S", s8, 0);
        chk("midrst Co", co8, 0);
        chk("midrst OVF", ovf8, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst stale%0d", i), ov8, 0);
        end
        run_vec('{8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0}, "postrst");

        // 16-bit sweep: every result checked against the model at exactly STAGES cycles
        @(posedge clk); #1;
        sw_base = cyc;
        sw_chk  = 1'b1;
        for (int n = 0; n < SW_N; n++) begin
            hv[n]   = ($urandom_range(0, 3) != 0);
            ha[n]   = 16'($urandom);
            hb[n]   = 16'($urandom);
            hci[n]  = 1'($urandom);
            hsub[n] = 1'($urandom);
            if (n == 0) begin hv[n] = 1'b1; ha[n] = 16'hFFFF; hb[n] = 16'h0001; hsub[n] = 1'b0; hci[n] = 1'b0; end
            if (n == 1) begin hv[n] = 1'b1; ha[n] = 16'h7FFF; hb[n] = 16'h0001; hsub[n] = 1'b0; hci[n] = 1'b0; end
            if (n == 2) begin hv[n] = 1'b1; ha[n] = 16'h8000; hb[n] = 16'h0001; hsub[n] = 1'b1; hci[n] = 1'b1; end
            iv16 = hv[n]; a16 = ha[n]; b16 = hb[n]; ci16 = hci[n]; sub16 = hsub[n];
            @(posedge clk); #1;
        end
        iv16 = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        sw_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
